cayde_writeback: RTL
====================

// Module: cayde_writeback
// PURPOSE
//  Writeback stage directly upstream of the register-file write port.
//  - Takes completed instructions from execute over a valid/ready handshake.
//  - Waits for load data from the data memory when needed, then aligns and extends it.
//  - Drives one registered write (waddr/wdata/wen) per instruction into the regfile.
//  - Mirrors the in-flight write on a bypass port for decode.
// PARAMETERS
//  XLEN      32  data width
//  RADDR_W   5   register index width
//  CNT_W     64  retire counter width (used only with CAYDE_WB_INSTRET_EN)
// PORTS
//  clk             in   1        clock
//  rst             in   1        reset, synchronous, active-high
//  ex_valid_in     in   1        execute result valid
//  ex_ready_out    out  1        stage can accept
//  ex_rd_in        in   RADDR_W  destination register
//  ex_result_in    in   XLEN     ALU result (address for loads)
//  ex_is_load_in   in   1        instruction is a load
//  ex_funct3_in    in   3        load size/sign
//  dmem_rvalid_in  in   1        load data valid
//  dmem_rdata_in   in   XLEN     load word (aligned 32-bit)
//  waddr_out       out  RADDR_W  regfile write address
//  wdata_out       out  XLEN     regfile write data
//  wen_out         out  1        regfile write enable
//  fwd_valid_out   out  1        bypass valid (== wen_out)
//  fwd_rd_out      out  RADDR_W  bypass register (== waddr_out)
//  fwd_data_out    out  XLEN     bypass data (== wdata_out)
//  ld_err_out      out  1        1-cycle pulse: misaligned/illegal load
//  instret_out     out  CNT_W    retired count (macro only)
// BEHAVIOUR
//  - States: IDLE, WAIT_MEM, WRITE.
//  - ex_ready_out = (state != WAIT_MEM). Accept = ex_valid_in & ex_ready_out.
//  - Accept non-load: latch rd/result, go WRITE. wen_out is high the next cycle.
//    Latency 1, so back-to-back accepts give 1 write/cycle.
//  - Accept legal load: latch rd/funct3/addr[1:0], go WAIT_MEM.
//    Stay there until dmem_rvalid_in. Then latch the extracted data and go WRITE;
//    wen_out is high the cycle after rvalid.
//  - Extraction, using addr[1:0] to select the byte/half:
//    - 000 LB: sign-extend byte.  100 LBU: zero-extend byte.
//    - 001 LH: sign-extend half[addr[1]].  101 LHU: zero-extend half[addr[1]].
//    - 010 LW: full word.
//  - Illegal load (funct3 011/110/111, LH/LHU with addr[0]=1, LW with addr[1:0]!=0):
//    ld_err_out pulses the cycle after accept, no write, stay/return IDLE.
//  - WRITE with no new accept: return IDLE. WRITE with accept: follow the accept rules.
//  - rd==0: wen_out stays 0, but the instruction still retires. x0 is never written.
//  - dmem_rvalid_in outside WAIT_MEM is ignored.
//  - wen_out is a single-cycle pulse per instruction. waddr_out/wdata_out hold their last values when wen_out=0.
//  - Reset (takes priority over everything, including mid-WAIT_MEM):
//    - State goes to IDLE and any pending load is dropped.
//    - wen_out=0, ld_err_out=0, waddr_out=0, wdata_out=0, instret_out=0.
//    - ex_ready_out=1 the cycle after reset deasserts.
// CONFIGURATION
//  - CAYDE_WB_INSTRET_EN defined: instret_out increments by 1 in each cycle that a
//    retiring write is presented (WRITE state, rd==0 included, errors excluded).
//    Wraps modulo 2^CNT_W.
//  - Undefined: counter logic is absent and instret_out is tied to 0.
// TESTING
//  - ALU: accept rd=5, result=0xDEADBEEF -> next cycle wen=1, waddr=5, wdata=0xDEADBEEF;
//    the cycle after that wen=0.
//  - Back-to-back: rd=1..4 on 4 consecutive cycles -> 4 consecutive wen pulses, in order,
//    with ex_ready_out held high.
//  - Loads on dmem word 0x80F17F02:
//    - LB addr[1:0]=3 -> 0xFFFFFF80.
//    - LBU addr[1:0]=2 -> 0x000000F1.
//    - LH addr[1:0]=2 -> 0xFFFF80F1.
//    - LW after 3-cycle rvalid delay -> wen 1 cycle after rvalid; ready low the whole wait.
//  - LW addr[1:0]=2 -> ld_err pulse, no wen. funct3=011 -> same.
//    rd=0 ALU -> no wen, instret +1 (macro on).
//  - rst asserted during WAIT_MEM, then a stray rvalid -> no wen, state IDLE, ready=1,
//    instret_out=0.

Source files
------------

// File: rtl/cayde_writeback_if.sv
// Handshake/bus bundle for the cayde_writeback stage: execute-side request,
// data-memory load return, regfile write port, decode bypass and retire count.
interface cayde_writeback_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 64
);
  logic               ex_valid_in;
  logic               ex_ready_out;
  logic [RADDR_W-1:0] ex_rd_in;
  logic [XLEN-1:0]    ex_result_in;
  logic               ex_is_load_in;
  logic [2:0]         ex_funct3_in;
  logic               dmem_rvalid_in;
  logic [XLEN-1:0]    dmem_rdata_in;
  logic [RADDR_W-1:0] waddr_out;
  logic [XLEN-1:0]    wdata_out;
  logic               wen_out;
  logic               fwd_valid_out;
  logic [RADDR_W-1:0] fwd_rd_out;
  logic [XLEN-1:0]    fwd_data_out;
  logic               ld_err_out;
  logic [CNT_W-1:0]   instret_out;

  // Upstream side: execute + data memory drive, observes writeback results.
  modport master (
    output ex_valid_in, ex_rd_in, ex_result_in, ex_is_load_in, ex_funct3_in,
    output dmem_rvalid_in, dmem_rdata_in,
    input  ex_ready_out, waddr_out, wdata_out, wen_out,
    input  fwd_valid_out, fwd_rd_out, fwd_data_out, ld_err_out, instret_out
  );

  // The writeback stage itself.
  modport slave (
    input  ex_valid_in, ex_rd_in, ex_result_in, ex_is_load_in, ex_funct3_in,
    input  dmem_rvalid_in, dmem_rdata_in,
    output ex_ready_out, waddr_out, wdata_out, wen_out,
    output fwd_valid_out, fwd_rd_out, fwd_data_out, ld_err_out, instret_out
  );
endinterface

// File: rtl/cayde_writeback.sv
// Writeback stage in front of the regfile write port. Accepts completed
// instructions from execute, waits for load data when needed, aligns and
// extends it, and issues one registered regfile write per instruction, which
// is mirrored on the bypass port for decode.
// Optional feature: define CAYDE_WB_INSTRET_EN to build the retire counter;
// otherwise instret_out is tied to zero.
module cayde_writeback #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 64
) (
  input logic              clk,
  input logic              rst,
  cayde_writeback_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

  state_t             state;
  logic [RADDR_W-1:0] ld_rd;
  logic [2:0]         ld_funct3;
  logic [1:0]         ld_off;
  logic [RADDR_W-1:0] waddr;
  logic [XLEN-1:0]    wdata;
  logic               wen;
  logic               ld_err;
  logic               accept;
  logic               acc_legal;

  // A legal load: LB/LBU any offset, LH/LHU halfword aligned, LW word aligned.
  function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: load_legal = 1'b1;
      3'b001, 3'b101: load_legal = ~off[0];
      3'b010:         load_legal = (off == 2'b00);
      default:        load_legal = 1'b0;
    endcase
  endfunction

  // Select the byte/half addressed by off and sign- or zero-extend it.
  function automatic logic [XLEN-1:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extract = {{(XLEN-8){b[7]}}, b};
      3'b100:  extract = {{(XLEN-8){1'b0}}, b};
      3'b001:  extract = {{(XLEN-16){h[15]}}, h};
      3'b101:  extract = {{(XLEN-16){1'b0}}, h};
      default: extract = word;
    endcase
  endfunction

  assign bus.ex_ready_out = (state != WAIT_MEM);
  assign accept           = bus.ex_valid_in & bus.ex_ready_out;
  assign acc_legal        = load_legal(bus.ex_funct3_in, bus.ex_result_in[1:0]);

  // Main FSM; every write/error output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ld_rd     <= '0;
      ld_funct3 <= '0;
      ld_off    <= '0;
      waddr     <= '0;
      wdata     <= '0;
      wen       <= 1'b0;
      ld_err    <= 1'b0;
    end else begin
      wen    <= 1'b0;
      ld_err <= 1'b0;
      case (state)
        WAIT_MEM: begin
          // rvalid only matters here; x0 retires without touching the write port.
          if (bus.dmem_rvalid_in) begin
            state <= WRITE;
            if (ld_rd != '0) begin
              wen   <= 1'b1;
              waddr <= ld_rd;
              wdata <= extract(ld_funct3, ld_off, bus.dmem_rdata_in);
            end
          end
        end
        default: begin
          // IDLE and WRITE both take a new instruction; WRITE drains to IDLE otherwise.
          state <= IDLE;
          if (accept) begin
            if (!bus.ex_is_load_in) begin
              state <= WRITE;
              if (bus.ex_rd_in != '0) begin
                wen   <= 1'b1;
                waddr <= bus.ex_rd_in;
                wdata <= bus.ex_result_in;
              end
            end else if (!acc_legal) begin
              ld_err <= 1'b1;
            end else begin
              state     <= WAIT_MEM;
              ld_rd     <= bus.ex_rd_in;
              ld_funct3 <= bus.ex_funct3_in;
              ld_off    <= bus.ex_result_in[1:0];
            end
          end
        end
      endcase
    end
  end

  assign bus.waddr_out     = waddr;
  assign bus.wdata_out     = wdata;
  assign bus.wen_out       = wen;
  assign bus.ld_err_out    = ld_err;
  assign bus.fwd_valid_out = wen;
  assign bus.fwd_rd_out    = waddr;
  assign bus.fwd_data_out  = wdata;

`ifdef CAYDE_WB_INSTRET_EN
  logic [CNT_W-1:0] instret;

  // Count every cycle a retirement is presented (WRITE), x0 included.
  always_ff @(posedge clk) begin
    if (rst) instret <= '0;
    else if (state == WRITE) instret <= instret + 1'b1;
  end

  assign bus.instret_out = instret;
`else
  assign bus.instret_out = '0;
`endif

endmodule
